// File: rtl/simple_stream_generator_if.sv
// ---------------------------------------------------------------------------
// simple_stream_generator_if
// AXI-Stream channel between the pattern generator and the channel under test.
//   input_r_TREADY_0  downstream ready (driven by the sink)
//   input_r_TVALID_0  stream valid      (driven by the generator)
//   input_r_TLAST_0   last beat of packet
//   input_r_TDATA_0   32-bit stream data
// Modports: master = generator side, slave = sink side.
// ---------------------------------------------------------------------------
interface simple_stream_generator_if;
  logic        input_r_TREADY_0;
  logic        input_r_TVALID_0;
  logic        input_r_TLAST_0;
  logic [31:0] input_r_TDATA_0;

  modport master (
    input  input_r_TREADY_0,
    output input_r_TVALID_0,
    output input_r_TLAST_0,
    output input_r_TDATA_0
  );

  modport slave (
    output input_r_TREADY_0,
    input  input_r_TVALID_0,
    input  input_r_TLAST_0,
    input  input_r_TDATA_0
  );
endinterface

// File: rtl/simple_stream_generator.sv
// ---------------------------------------------------------------------------
// simple_stream_generator
// AXI-Stream pattern transmitter. After Start_Delay_Value cycles it sends
// packets of Packet_Length incrementing 32-bit words (first word 1), with
// Gap_Cycles idle cycles after each packet, stopping after Num_Packets
// packets (0 = forever). A single word can be corrupted (bit 0 inverted)
// on request for negative testing of the receive-side checker.
// Ports:
//   clk           single rising-edge clock
//   reset         asynchronous active-low reset
//   inject_error  one-cycle request to corrupt the next newly loaded word
//   input_r       stream master (TVALID/TLAST/TDATA out, TREADY in)
//   Word_Counter  number of accepted beats
//   Done          sticky, high once Num_Packets packets were accepted
// ---------------------------------------------------------------------------
module simple_stream_generator #(
  parameter logic [19:0] Start_Delay_Value = 20'd20000,
  parameter int unsigned Packet_Length     = 16,
  parameter int unsigned Num_Packets       = 0,
  parameter int unsigned Gap_Cycles        = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inject_error,
  simple_stream_generator_if.master input_r,
  output logic [31:0]               Word_Counter,
  output logic                      Done
);

  typedef enum logic [1:0] {WAIT_START, SEND, GAP, DONE} state_t;

  localparam logic [15:0] LAST_BEAT = 16'(Packet_Length - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(Gap_Cycles - 1);

  state_t      state, state_n;
  logic [19:0] delay_cnt, delay_n;
  logic [7:0]  gap_cnt, gap_n;
  logic [31:0] data_cnt, data_n;
  logic [15:0] beat_cnt, beat_n;
  logic [31:0] pkt_cnt, pkt_n;
  logic        err_pending, err_n;
  logic        tvalid, tvalid_n;
  logic        tlast, tlast_n;
  logic [31:0] tdata, tdata_n;
  logic [31:0] word_cnt, word_n;
  logic        done_flag, done_n;

  logic        tready;
  logic        load;
  logic [31:0] load_data;
  logic [15:0] load_beat;

  assign tready                   = input_r.input_r_TREADY_0;
  assign input_r.input_r_TVALID_0 = tvalid;
  assign input_r.input_r_TLAST_0  = tlast;
  assign input_r.input_r_TDATA_0  = tdata;
  assign Word_Counter             = word_cnt;
  assign Done                     = done_flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_START;
      delay_cnt   <= '0;
      gap_cnt     <= '0;
      data_cnt    <= 32'd1;
      beat_cnt    <= '0;
      pkt_cnt     <= '0;
      err_pending <= 1'b0;
      tvalid      <= 1'b0;
      tlast       <= 1'b0;
      tdata       <= '0;
      word_cnt    <= '0;
      done_flag   <= 1'b0;
    end else begin
      state       <= state_n;
      delay_cnt   <= delay_n;
      gap_cnt     <= gap_n;
      data_cnt    <= data_n;
      beat_cnt    <= beat_n;
      pkt_cnt     <= pkt_n;
      err_pending <= err_n;
      tvalid      <= tvalid_n;
      tlast       <= tlast_n;
      tdata       <= tdata_n;
      word_cnt    <= word_n;
      done_flag   <= done_n;
    end
  end

  // 'load' marks every edge where a fresh word goes onto the bus; the
  // word's data and beat position are chosen per state, and the shared
  // block at the bottom presents it (this is also the only place where
  // a pending error may corrupt a word, so stalled words are never touched).
  always_comb begin
    state_n   = state;
    delay_n   = delay_cnt;
    gap_n     = gap_cnt;
    data_n    = data_cnt;
    beat_n    = beat_cnt;
    pkt_n     = pkt_cnt;
    tvalid_n  = tvalid;
    tlast_n   = tlast;
    tdata_n   = tdata;
    word_n    = word_cnt;
    done_n    = done_flag;
    err_n     = err_pending;
    load      = 1'b0;
    load_data = data_cnt;
    load_beat = beat_cnt;

    case (state)
      WAIT_START: begin
        if (delay_cnt == Start_Delay_Value) begin
          load    = 1'b1;
          state_n = SEND;
        end else begin
          delay_n = delay_cnt + 20'd1;
        end
      end
      SEND: begin
        if (tvalid && tready) begin
          data_n    = data_cnt + 32'd1;
          word_n    = word_cnt + 32'd1;
          load_data = data_cnt + 32'd1;
          if (tlast) begin
            beat_n = '0;
            pkt_n  = pkt_cnt + 32'd1;
            if (Num_Packets != 0 && (pkt_cnt + 32'd1) == Num_Packets) begin
              state_n  = DONE;
              tvalid_n = 1'b0;
              tlast_n  = 1'b0;
              done_n   = 1'b1;
            end else if (Gap_Cycles != 0) begin
              state_n  = GAP;
              gap_n    = '0;
              tvalid_n = 1'b0;
              tlast_n  = 1'b0;
            end else begin
              load      = 1'b1;
              load_beat = '0;
            end
          end else begin
            beat_n    = beat_cnt + 16'd1;
            load      = 1'b1;
            load_beat = beat_cnt + 16'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          load    = 1'b1;
          state_n = SEND;
        end else begin
          gap_n = gap_cnt + 8'd1;
        end
      end
      DONE: begin
        tvalid_n = 1'b0;
        tlast_n  = 1'b0;
        done_n   = 1'b1;
      end
      default: state_n = WAIT_START;
    endcase

    if (load) begin
      tvalid_n = 1'b1;
      tlast_n  = (load_beat == LAST_BEAT);
      tdata_n  = load_data ^ {31'd0, err_pending};
    end

    // A request arriving on a load edge targets the word after the one
    // being loaded; a request while one is already pending is dropped.
    if (state != DONE) begin
      if (load) err_n = inject_error & ~err_pending;
      else      err_n = err_pending | inject_error;
    end
  end

endmodule
